// File: rtl/aes128_type_pkg.sv
// Shared types and constants for the AES128 datapath blocks.
// Holds the GF(2^8) multiplier FSM states and the AES reduction constant.
package aes128_type_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } gmul_state_e;

  // x^8 + x^4 + x^3 + x + 1 with the x^8 term implied by the carry-out
  localparam logic [7:0] AES_GF_POLY = 8'h1B;

endpackage

// File: rtl/aes128_xtime.sv
// Combinational GF(2^8) multiply-by-x: shift left one bit and fold the
// carry-out back in with the reduction constant.
module aes128_xtime #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = {in_byte[6:0], 1'b0} ^ (in_byte[7] ? POLY : 8'h00);

endmodule

// File: rtl/aes128_gmul_lanes.sv
// Sequential shift-and-add GF(2^8) multiplier: LANES bytes times one shared
// coefficient, stopping after the coefficient's highest set bit.
module aes128_gmul_lanes
  import aes128_type_pkg::*;
#(
  parameter int         LANES  = 4,
  parameter int         COEF_W = 4,
  parameter logic [7:0] POLY   = AES_GF_POLY
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic [COEF_W-1:0]    a_i,
  input  logic [LANES*8-1:0]   b_i,
  output logic [LANES*8-1:0]   result_o,
  output logic                 valid_o,
  output logic                 busy_o
);

  localparam int BIT_W = (COEF_W > 1) ? $clog2(COEF_W) : 1;

  gmul_state_e          state_r;
  gmul_state_e          state_s;
  logic [COEF_W-1:0]    a_r;
  logic [LANES*8-1:0]   work_r;
  logic [LANES*8-1:0]   result_r;
  logic [LANES*8-1:0]   xt_s;
  logic [BIT_W-1:0]     bit_r;
  logic [BIT_W-1:0]     hi_s;
  logic                 last_s;
  logic                 add_s;

  // Priority encoder: index of the highest set coefficient bit (0 when a_r is 0)
  always_comb begin
    hi_s = '0;
    for (int i = 0; i < COEF_W; i++) begin
      if (a_r[i]) begin
        hi_s = BIT_W'(i);
      end else begin
        hi_s = hi_s;
      end
    end
  end

  assign last_s = (bit_r == hi_s);
  assign add_s  = a_r[bit_r];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes128_xtime #(.POLY(POLY)) u_xtime (
      .in_byte  (work_r[8*k +: 8]),
      .out_byte (xt_s[8*k +: 8])
    );
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = ADD;
        end else begin
          state_s = IDLE;
        end
      end
      ADD: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      SHIFT:   state_s = ADD;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand capture and shift/add datapath; all lanes share bit_r and a_r
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_r      <= '0;
      work_r   <= '0;
      result_r <= '0;
      bit_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            a_r      <= a_i;
            work_r   <= b_i;
            result_r <= '0;
            bit_r    <= '0;
          end
        end
        ADD: begin
          if (add_s) begin
            result_r <= result_r ^ work_r;
          end
          if (!last_s) begin
            bit_r <= bit_r + BIT_W'(1);
          end
        end
        SHIFT: begin
          work_r <= xt_s;
        end
        DONE: begin
          result_r <= result_r;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign ready_o  = (state_r == IDLE);
  assign busy_o   = ~ready_o;
  assign valid_o  = (state_r == DONE);
  assign result_o = result_r;

endmodule

// File: tb/tb_aes128_gmul_lanes.sv
// Scoreboard bench for aes128_gmul_lanes: a polynomial-arithmetic reference
// model predicts each accepted transaction's product and completion cycle.
module tb_aes128_gmul_lanes;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  a_i = 4'h0;
  logic [31:0] b_i = 32'h0;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] result_o;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = 8'h00;
  logic [7:0]  b8 = 8'h00;
  logic        ready8, valid8, busy8;
  logic [7:0]  result8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_free = 0;
  int   acc_cnt = 0;
  int   rst_cnt = 0;
  int   rst_seen = 0;
  logic mon_en = 1'b0;
  logic [31:0] last_res = 32'h0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  aes128_gmul_lanes dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .result_o(result_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  aes128_gmul_lanes #(.LANES(1), .COEF_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start8), .ready_o(ready8),
    .a_i(a8), .b_i(b8), .result_o(result8), .valid_o(valid8), .busy_o(busy8)
  );

  // Carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (a[i]) p = p ^ (16'(b) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] gf_lanes(input logic [3:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = gf_mul({4'h0, a}, b[8*k +: 8]);
    return r;
  endfunction

  function automatic int hibit(input logic [7:0] a);
    int h;
    h = 0;
    for (int i = 0; i < 8; i++) if (a[i]) h = i;
    return h;
  endfunction

  // Reference model: decides acceptance and predicts result and completion cycle
  always @(posedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      next_free <= cyc + 1;
      rst_cnt   <= rst_cnt + 1;
    end else if (start_i && cyc >= next_free) begin
      exp_q.push_back('{gf_lanes(a_i, b_i), cyc + 2 + 2 * hibit({4'h0, a_i})});
      next_free <= cyc + 3 + 2 * hibit({4'h0, a_i});
      acc_cnt   <= acc_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  // Monitor: compares handshake, valid pulse and result against the model
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen != rst_cnt) begin
        rst_seen = rst_cnt;
        last_res = 32'h0;
      end
      checks++;
      if (ready_o !== (cyc >= next_free) || busy_o !== (cyc < next_free)) begin
        errors++;
        $display("FAIL handshake cyc=%0d: ready=%b busy=%b expected ready=%b", cyc, ready_o, busy_o, cyc >= next_free);
      end
      checks++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (valid_o !== 1'b1 || result_o !== exp_q[0].res) begin
          errors++;
          $display("FAIL result cyc=%0d: valid=%b result=%h expected valid=1 result=%h", cyc, valid_o, result_o, exp_q[0].res);
        end
        last_res = exp_q[0].res;
        void'(exp_q.pop_front());
      end else if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL spurious_valid cyc=%0d: valid=%b expected 0", cyc, valid_o);
      end
      if (cyc >= next_free) begin
        checks++;
        if (result_o !== last_res) begin
          errors++;
          $display("FAIL result_hold cyc=%0d: result=%h expected %h", cyc, result_o, last_res);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [3:0] a, input logic [31:0] b, output int t0);
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_valid(input string name, input int t0, input logic [31:0] want, input int lat);
    int n;
    n = 0;
    while (valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, {31'h0, valid_o}, 32'h1);
    check({name, "_res"}, result_o, want);
    check({name, "_lat"}, 32'(cyc - t0), 32'(lat));
    @(negedge clk);
    check({name, "_pulse"}, {31'h0, valid_o}, 32'h0);
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] want, input int lat);
    int t0, n;
    @(negedge clk);
    check({name, "_ready"}, {31'h0, ready8}, 32'h1);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    t0 = cyc - 1;
    n = 0;
    while (valid8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, {31'h0, valid8}, 32'h1);
    check({name, "_res"}, {24'h0, result8}, {24'h0, want});
    check({name, "_lat"}, 32'(cyc - t0), 32'(lat));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < next_free && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int t0, n, base;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check("reset_ready", {31'h0, ready_o}, 32'h1);
    check("reset_busy", {31'h0, busy_o}, 32'h0);
    check("reset_valid", {31'h0, valid_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    mon_en = 1'b1;

    issue(4'h2, 32'h455313DB, t0);
    wait_valid("mixcol", t0, 32'h8AA626AD, 4);
    wait_idle();
    issue(4'hE, 32'h00000057, t0);
    wait_valid("fips_e", t0, 32'h00000067, 8);
    wait_idle();
    issue(4'h1, 32'h00000057, t0);
    wait_valid("fips_1", t0, 32'h00000057, 2);
    wait_idle();

    run8("sweep_13", 8'h13, 8'h57, 8'hFE, 10);
    run8("sweep_83", 8'h83, 8'h57, 8'hC1, 16);
    run8("sweep_00", 8'h00, 8'h57, 8'h00, 2);

    // Starts and input changes while busy must not disturb the running op
    wait_idle();
    issue(4'hE, 32'hA1B2C357, t0);
    a_i = 4'h7; b_i = 32'h11223344;
    @(negedge clk);
    start_i = 1'b1; a_i = 4'h2; b_i = 32'hDEADBEEF;
    @(negedge clk);
    start_i = 1'b0; a_i = 4'h5; b_i = $urandom;
    wait_valid("busy_ign", t0, gf_lanes(4'hE, 32'hA1B2C357), 8);
    wait_idle();

    issue(4'hE, 32'h12345678, t0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midrst_ready", {31'h0, ready_o}, 32'h1);
    check("midrst_valid", {31'h0, valid_o}, 32'h0);
    check("midrst_result", result_o, 32'h0);
    repeat (10) @(negedge clk);
    issue(4'h3, 32'h0F1E2D3C, t0);
    wait_valid("after_rst", t0, gf_lanes(4'h3, 32'h0F1E2D3C), 4);
    wait_idle();

    // Held start with a=2: the monitor checks the 5-cycle accept cadence
    base = acc_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start_i = 1'b1; a_i = 4'h2; b_i = $urandom;
    end
    check("b2b_accepts", 32'(acc_cnt - base), 32'd10);

    base = acc_cnt;
    n = 0;
    while (acc_cnt - base < 1000 && n < 20000) begin
      @(negedge clk);
      start_i = 1'b1; a_i = 4'($urandom_range(0, 15)); b_i = $urandom;
      n++;
    end
    @(negedge clk);
    start_i = 1'b0;
    check("random_count_reached", {31'h0, n < 20000}, 32'h1);

    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
